// File: rtl/module_period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and the
// default measurement timeout.
package module_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 32'h3FFF_FFFF;

endpackage

// File: rtl/module_sync_edge_detect.sv
// Synchronizes an asynchronous input and emits a one-cycle pulse on each
// rising edge of the synchronized signal.
module module_sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic signal_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   old_q, old_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], signal_in};
        old_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
            old_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            old_q  <= old_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~old_q;

endmodule

// File: rtl/module_period_meter.sv
// Measures the period of a slow asynchronous signal in clk_in cycles between
// consecutive rising edges, with single-shot or back-to-back operation.
module module_period_meter
    import module_period_meter_pkg::*;
#(
    parameter int          WIDTH       = 30,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             signal_in,
    input  logic             start,
    input  logic             continuous,
    input  logic             ack,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] half_period_out,
    output logic             valid,
    output logic             busy,
    output logic             timeout
);

    // Timeout fires when the counter is about to reach this value, so the
    // counter can never wrap.
    localparam logic [WIDTH-1:0] COUNT_LAST = WIDTH'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] half_q, half_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] count_inc;
    logic             at_limit;
    logic             rise;

    module_sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk_in   (clk_in),
        .reset    (reset),
        .signal_in(signal_in),
        .rise     (rise)
    );

    assign count_inc = count_q + WIDTH'(1);
    assign at_limit  = (count_inc == COUNT_LAST);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        half_d    = half_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;

        // A result landing in the same cycle overrides the acknowledge below.
        if (ack) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_ARM;
                    count_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_ARM: begin
                count_d = count_inc;
                if (rise) begin
                    state_d = ST_COUNT;
                    count_d = WIDTH'(1);
                end else if (at_limit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_COUNT: begin
                count_d = count_inc;
                if (rise) begin
                    period_d  = count_q;
                    half_d    = count_q >> 1;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    // The closing edge of this period opens the next one.
                    count_d   = WIDTH'(1);
                    if (!continuous) begin
                        state_d = ST_DONE;
                    end
                end else if (at_limit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            period_q  <= '0;
            half_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            half_q    <= half_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_out      = period_q;
    assign half_period_out = half_q;
    assign valid           = valid_q;
    assign timeout         = timeout_q;
    assign busy            = (state_q == ST_ARM) || (state_q == ST_COUNT);

endmodule
